mem_access_unit: RTL and testbench

Sequential load/store executor for the MEM stage: consumes the 3-bit `WidthSrc` width code and the byte address, and runs one or two handshaked word-bus transactions. Stores are driven with byte strobes and lane-shifted data; loads are reassembled and sign- or zero-extended. Accesses that cross a word boundary are split into two beats. `Stall` holds the pipeline while an access is in flight.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_align.sv | 60 ++++++
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared width codes, FSM encoding and size decode
// for the MEM-stage load/store executor.
package mem_pkg;

  localparam logic [2:0] WS_WORD  = 3'b000;
  localparam logic [2:0] WS_HALF  = 3'b010;
  localparam logic [2:0] WS_BYTE  = 3'b001;
  localparam logic [2:0] WS_HALFU = 3'b110;
  localparam logic [2:0] WS_BYTEU = 3'b101;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Byte count of an access; zero marks an illegal code
  function automatic logic [2:0] accessSize(
    input logic [2:0] ws
  );
    logic [2:0] n;
    n = 3'd0;
    unique case (ws)
      WS_WORD:            n = 3'd4;
      WS_HALF, WS_HALFU:  n = 3'd2;
      WS_BYTE, WS_BYTEU:  n = 3'd1;
      default:            n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic isIllegal(
    input logic [2:0] ws
  );
    return accessSize(ws) == 3'd0;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for stores and merge/extension
// for loads; purely combinational.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [31:0] writeData,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  input  logic [1:0]  loadOff,
  input  logic [2:0]  loadWidth,
  input  logic [31:0] r0,
  input  logic [31:0] r1,
  output logic [31:0] loadData
);

  logic [3:0]  mask;
  logic [7:0]  beWide;
  logic [63:0] dataWide;
  logic [63:0] mergeWide;
  logic [31:0] raw;
  logic [2:0]  loadSize;
  logic        sgn;

  always_comb begin
    mask = 4'b0000;
    unique case (size)
      3'd4:    mask = 4'b1111;
      3'd2:    mask = 4'b0011;
      3'd1:    mask = 4'b0001;
      default: mask = 4'b0000;
    endcase
  end

  // Upper halves of the wide shifts are the spill into beat 1
  assign beWide   = {4'b0000, mask} << off;
  assign dataWide = {32'd0, writeData} << {off, 3'b000};
  assign be0      = beWide[3:0];
  assign be1      = beWide[7:4];
  assign wdata0   = dataWide[31:0];
  assign wdata1   = dataWide[63:32];

  assign mergeWide = {r1, r0} >> {loadOff, 3'b000};
  assign raw       = mergeWide[31:0];
  assign loadSize  = accessSize(loadWidth);
  assign sgn       = ~loadWidth[2];

  always_comb begin
    loadData = raw;
    unique case (loadSize)
      3'd1:    loadData = {{24{sgn & raw[7]}}, raw[7:0]};
      3'd2:    loadData = {{16{sgn & raw[15]}}, raw[15:0]};
      default: loadData = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store executor: one or two
// handshaked word-bus beats per access.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemWrite,
  input  logic [2:0]            WidthSrc,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           WriteData,
  output logic [31:0]           LoadData,
  output logic                  resp_valid,
  output logic                  err,
  output logic                  Stall,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata
);

  logic [1:0]  state;
  logic [1:0]  offQ;
  logic [2:0]  widthQ;
  logic        weQ;
  logic        crossQ;
  logic [3:0]  be1Q;
  logic [31:0] wdata1Q;
  logic [31:0] r0Q;

  logic [2:0]  reqSize;
  logic [1:0]  reqOff;
  logic        reqCross;
  logic [3:0]  be0;
  logic [3:0]  be1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [31:0] loadR0;
  logic [31:0] loadR1;
  logic [31:0] loadResult;

  assign reqSize  = accessSize(WidthSrc);
  assign reqOff   = Addr[1:0];
  assign reqCross = (reqSize == 3'd4 && reqOff != 2'd0)
                 || (reqSize == 3'd2 && reqOff == 2'd3);

  // Bypass the acked beat so the result is ready on entry to RESP
  assign loadR0 = (state == S_BEAT0) ? bus_rdata : r0Q;
  assign loadR1 = (state == S_BEAT1) ? bus_rdata : 32'd0;

  mem_align u_align (
    .off       (reqOff),
    .size      (reqSize),
    .writeData (WriteData),
    .be0       (be0),
    .be1       (be1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .loadOff   (offQ),
    .loadWidth (widthQ),
    .r0        (loadR0),
    .r1        (loadR1),
    .loadData  (loadResult)
  );

  assign req_ready = (state == S_IDLE);
  assign Stall = (state == S_BEAT0) || (state == S_BEAT1)
              || (state == S_IDLE && req_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      offQ       <= 2'd0;
      widthQ     <= 3'd0;
      weQ        <= 1'b0;
      crossQ     <= 1'b0;
      be1Q       <= 4'd0;
      wdata1Q    <= 32'd0;
      r0Q        <= 32'd0;
      LoadData   <= 32'd0;
      resp_valid <= 1'b0;
      err        <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= 4'd0;
      bus_wdata  <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      err        <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            offQ    <= reqOff;
            widthQ  <= WidthSrc;
            weQ     <= MemWrite;
            crossQ  <= reqCross;
            be1Q    <= be1;
            wdata1Q <= wdata1;
            if (isIllegal(WidthSrc)) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              err        <= 1'b1;
              LoadData   <= 32'd0;
            end else begin
              state     <= S_BEAT0;
              bus_req   <= 1'b1;
              bus_we    <= MemWrite;
              bus_addr  <= {Addr[ADDR_WIDTH-1:2], 2'b00};
              bus_be    <= be0;
              bus_wdata <= wdata0;
            end
          end
        end
        S_BEAT0: begin
          if (bus_ack) begin
            r0Q <= bus_rdata;
            if (crossQ) begin
              state     <= S_BEAT1;
              bus_addr  <= bus_addr + ADDR_WIDTH'(4);
              bus_be    <= be1Q;
              bus_wdata <= wdata1Q;
            end else begin
              state      <= S_RESP;
              bus_req    <= 1'b0;
              bus_we     <= 1'b0;
              resp_valid <= 1'b1;
              LoadData   <= weQ ? 32'd0 : loadResult;
            end
          end
        end
        S_BEAT1: begin
          if (bus_ack) begin
            state      <= S_RESP;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            resp_valid <= 1'b1;
            LoadData   <= weQ ? 32'd0 : loadResult;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a
// hand-driven word bus.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        MemWrite;
  logic [2:0]  WidthSrc;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] LoadData;
  logic        resp_valid;
  logic        err;
  logic        Stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int nChecks = 0;
  int nFails  = 0;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .MemWrite   (MemWrite),
    .WidthSrc   (WidthSrc),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .LoadData   (LoadData),
    .resp_valid (resp_valid),
    .err        (err),
    .Stall      (Stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then withdraw it
  task automatic issue(input logic we, input logic [2:0] ws,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    MemWrite  = we;
    WidthSrc  = ws;
    Addr      = a;
    WriteData = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    nChecks++;
    if ({bus_req, bus_we, resp_valid, err, Stall} !== 5'b0) begin
      nFails++;
      $display("FAIL reset_flags: got %b want 00000",
               {bus_req, bus_we, resp_valid, err, Stall});
    end
    nChecks++;
    if ({bus_addr, bus_be, bus_wdata, LoadData} !== 100'd0) begin
      nFails++;
      $display("FAIL reset_data: got %h %b %h %h want zeros",
               bus_addr, bus_be, bus_wdata, LoadData);
    end
    nChecks++;
    if (req_ready !== 1'b1) begin
      nFails++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_store_word();
    req_valid = 1'b1;
    MemWrite  = 1'b1;
    WidthSrc  = 3'b000;
    Addr      = 32'h100;
    WriteData = 32'hDEADBEEF;
    #1;
    nChecks++;
    if ({Stall, req_ready} !== 2'b11) begin
      nFails++;
      $display("FAIL sw_accept: got stall/ready %b want 11", {Stall, req_ready});
    end
    tick();
    req_valid = 1'b0;
    nChecks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata}
        !== {2'b11, 32'h100, 4'b1111, 32'hDEADBEEF}) begin
      nFails++;
      $display("FAIL sw_beat: got req %b we %b addr %h be %b wd %h want 1 1 00000100 1111 deadbeef",
               bus_req, bus_we, bus_addr, bus_be, bus_wdata);
    end
    nChecks++;
    if ({Stall, resp_valid} !== 2'b10) begin
      nFails++;
      $display("FAIL sw_t1: got stall/resp %b want 10", {Stall, resp_valid});
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    nChecks++;
    if ({resp_valid, err, LoadData, bus_req, Stall, req_ready}
        !== {2'b10, 32'd0, 3'b000}) begin
      nFails++;
      $display("FAIL sw_resp: got rv %b err %b ld %h req %b stall %b rdy %b want 1 0 0 0 0 0",
               resp_valid, err, LoadData, bus_req, Stall, req_ready);
    end
    tick();
    nChecks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      nFails++;
      $display("FAIL sw_idle: got rv/rdy %b want 01", {resp_valid, req_ready});
    end
  endtask

  task automatic test_load_byte();
    issue(1'b0, 3'b001, 32'h103, 32'h0);
    nChecks++;
    if ({bus_req, bus_we, bus_addr, bus_be} !== {2'b10, 32'h100, 4'b1000}) begin
      nFails++;
      $display("FAIL lb_beat: got req %b we %b addr %h be %b want 1 0 00000100 1000",
               bus_req, bus_we, bus_addr, bus_be);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'h80123456;
    tick();
    bus_ack = 1'b0;
    nChecks++;
    if ({resp_valid, err, LoadData} !== {2'b10, 32'hFFFFFF80}) begin
      nFails++;
      $display("FAIL lb_data: got rv %b err %b ld %h want 1 0 ffffff80",
               resp_valid, err, LoadData);
    end
    tick();
    issue(1'b0, 3'b101, 32'h103, 32'h0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    nChecks++;
    if ({resp_valid, LoadData} !== {1'b1, 32'h00000080}) begin
      nFails++;
      $display("FAIL lbu_data: got rv %b ld %h want 1 00000080", resp_valid, LoadData);
    end
    tick();
    nChecks++;
    if ({resp_valid, LoadData} !== {1'b0, 32'h00000080}) begin
      nFails++;
      $display("FAIL lbu_hold: got rv %b ld %h want 0 00000080", resp_valid, LoadData);
    end
  endtask

  task automatic test_load_half_unsigned();
    issue(1'b0, 3'b110, 32'h202, 32'h0);
    nChecks++;
    if ({bus_addr, bus_be} !== {32'h200, 4'b1100}) begin
      nFails++;
      $display("FAIL lhu_beat: got addr %h be %b want 00000200 1100", bus_addr, bus_be);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'h8001_1234;
    tick();
    bus_ack = 1'b0;
    nChecks++;
    if ({resp_valid, LoadData} !== {1'b1, 32'h00008001}) begin
      nFails++;
      $display("FAIL lhu_data: got rv %b ld %h want 1 00008001", resp_valid, LoadData);
    end
    tick();
  endtask

  task automatic test_illegal();
    issue(1'b0, 3'b011, 32'h300, 32'h0);
    nChecks++;
    if ({resp_valid, err, LoadData, bus_req, Stall}
        !== {2'b11, 32'd0, 2'b00}) begin
      nFails++;
      $display("FAIL illegal_resp: got rv %b err %b ld %h req %b stall %b want 1 1 0 0 0",
               resp_valid, err, LoadData, bus_req, Stall);
    end
    tick();
    nChecks++;
    if ({resp_valid, err, req_ready, bus_req} !== 4'b0010) begin
      nFails++;
      $display("FAIL illegal_idle: got rv/err/rdy/req %b want 0010",
               {resp_valid, err, req_ready, bus_req});
    end
  endtask

  task automatic test_split_load();
    issue(1'b0, 3'b010, 32'h203, 32'h0);
    nChecks++;
    if ({bus_req, bus_addr, bus_be} !== {1'b1, 32'h200, 4'b1000}) begin
      nFails++;
      $display("FAIL lh_beat0: got req %b addr %h be %b want 1 00000200 1000",
               bus_req, bus_addr, bus_be);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'hAA000000;
    tick();
    nChecks++;
    if ({bus_req, bus_addr, bus_be, resp_valid, Stall}
        !== {1'b1, 32'h204, 4'b0001, 2'b01}) begin
      nFails++;
      $display("FAIL lh_beat1: got req %b addr %h be %b rv %b stall %b want 1 00000204 0001 0 1",
               bus_req, bus_addr, bus_be, resp_valid, Stall);
    end
    bus_rdata = 32'h000000BB;
    tick();
    bus_ack = 1'b0;
    nChecks++;
    if ({resp_valid, err, LoadData, bus_req} !== {2'b10, 32'hFFFFBBAA, 1'b0}) begin
      nFails++;
      $display("FAIL lh_data: got rv %b err %b ld %h req %b want 1 0 ffffbbaa 0",
               resp_valid, err, LoadData, bus_req);
    end
    tick();
  endtask

  task automatic test_split_store_wrap();
    issue(1'b1, 3'b000, 32'hFFFFFFFE, 32'h11223344);
    nChecks++;
    if ({bus_we, bus_addr, bus_be, bus_wdata}
        !== {1'b1, 32'hFFFFFFFC, 4'b1100, 32'h33440000}) begin
      nFails++;
      $display("FAIL sw_wrap_beat0: got we %b addr %h be %b wd %h want 1 fffffffc 1100 33440000",
               bus_we, bus_addr, bus_be, bus_wdata);
    end
    tick();
    nChecks++;
    if ({bus_req, bus_addr, bus_be, bus_wdata}
        !== {1'b1, 32'hFFFFFFFC, 4'b1100, 32'h33440000}) begin
      nFails++;
      $display("FAIL sw_wrap_hold: got req %b addr %h be %b wd %h want 1 fffffffc 1100 33440000",
               bus_req, bus_addr, bus_be, bus_wdata);
    end
    bus_ack = 1'b1;
    tick();
    nChecks++;
    if ({bus_we, bus_addr, bus_be, bus_wdata}
        !== {1'b1, 32'h00000000, 4'b0011, 32'h00001122}) begin
      nFails++;
      $display("FAIL sw_wrap_beat1: got we %b addr %h be %b wd %h want 1 00000000 0011 00001122",
               bus_we, bus_addr, bus_be, bus_wdata);
    end
    tick();
    bus_ack = 1'b0;
    nChecks++;
    if ({resp_valid, err, LoadData} !== {2'b10, 32'd0}) begin
      nFails++;
      $display("FAIL sw_wrap_resp: got rv %b err %b ld %h want 1 0 0",
               resp_valid, err, LoadData);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic sawResp;
    sawResp = 1'b0;
    issue(1'b0, 3'b000, 32'h40, 32'h0);
    nChecks++;
    if ({bus_req, bus_addr} !== {1'b1, 32'h40}) begin
      nFails++;
      $display("FAIL abort_beat: got req %b addr %h want 1 00000040", bus_req, bus_addr);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nChecks++;
    if ({bus_req, req_ready, resp_valid} !== 3'b010) begin
      nFails++;
      $display("FAIL abort_reset: got req/rdy/rv %b want 010",
               {bus_req, req_ready, resp_valid});
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      tick();
      sawResp = sawResp | resp_valid | bus_req;
    end
    bus_ack = 1'b0;
    nChecks++;
    if ({sawResp, req_ready, LoadData} !== {2'b01, 32'd0}) begin
      nFails++;
      $display("FAIL abort_late_ack: got activity %b rdy %b ld %h want 0 1 0",
               sawResp, req_ready, LoadData);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    MemWrite  = 1'b0;
    WidthSrc  = 3'b000;
    Addr      = 32'd0;
    WriteData = 32'd0;
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    test_reset();
    test_store_word();
    test_load_byte();
    test_illegal();
    test_load_half_unsigned();
    test_split_load();
    test_split_store_wrap();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
